// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: state geometry, InvSubBytes FSM states
// and the inverse S-box table reused by later decryption stages.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Entry 0 is the leftmost byte, so INV_SBOX[x] is the inverse S-box of x.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, its substitution out.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  assign result = INV_SBOX[value];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE state bytes per cycle,
// ascending byte order, with valid/ready handshakes on both sides.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] state_out,
  output logic         busy
);

  localparam int NUM_GROUPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  sub_state_t                 state, next_state;
  logic [CNT_W-1:0]           cnt;
  logic [0:AES_STATE_W-1]     buffer, next_buf;
  logic                       accept, last_group;
  logic [7:0]                 sbox_in  [BYTES_PER_CYCLE];
  logic [7:0]                 sbox_out [BYTES_PER_CYCLE];

  function automatic logic [6:0] byte_pos(input logic [CNT_W-1:0] g, input int i);
    return 7'((int'(g) * BYTES_PER_CYCLE + i) * 8);
  endfunction

  assign last_group = (cnt == CNT_W'(NUM_GROUPS - 1));
  assign accept     = in_valid && in_ready;
  assign state_out  = buffer;

  // Group mux: the counter selects which slice of the buffer feeds the S-boxes.
  always_comb begin
    next_buf = buffer;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      sbox_in[i] = buffer[byte_pos(cnt, i) +: 8];
      next_buf[byte_pos(cnt, i) +: 8] = sbox_out[i];
    end
  end

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
    inv_sbox u_sbox (
      .value  (sbox_in[i]),
      .result (sbox_out[i])
    );
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (last_group) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) next_state = in_valid ? SUB : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      buffer <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        buffer <= state_in;
        cnt    <= '0;
      end else if (state == SUB) begin
        buffer <= next_buf;
        cnt    <= last_group ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: GF(2^8)-derived reference model, per-cycle
// compare process on the default instance, plus directed latency/data vectors.
module tb_inv_sub_bytes_iter;

  localparam int NG = 4;
  localparam logic [0:127] FIPS_IN    = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [0:127] FIPS_OUT   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [0:127] CORNER_IN  = 128'h00630153ff00630153ff00630153ff00;
  localparam logic [0:127] CORNER_OUT = 128'h520009507d520009507d520009507d52;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] state_out;
  logic         busy;

  logic [3:0]   x_in_valid;
  logic [3:0]   x_in_ready;
  logic [3:0]   x_out_valid;
  logic [3:0]   x_busy;
  logic [0:127] x_state_out [4];

  int checks = 0;
  int failures = 0;
  int dut_xfers = 0;

  logic [7:0]   minv [256];
  int           m_busy = 0;
  bit           m_have = 0;
  bit           m_zero = 1;
  bit           mdl_started = 0;
  logic [0:127] m_data = '0;

  always #5 clock = ~clock;

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  // Extra widths: B = 1, 2, 8, 16 with the sink always ready.
  for (genvar gi = 0; gi < 4; gi++) begin : g_x
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(gi < 2 ? (1 << gi) : (1 << (gi + 1)))) u_x (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (x_in_valid[gi]),
      .in_ready  (x_in_ready[gi]),
      .state_in  (state_in),
      .out_valid (x_out_valid[gi]),
      .out_ready (1'b1),
      .state_out (x_state_out[gi]),
      .busy      (x_busy[gi])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:127] model_sub(input logic [0:127] d);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = minv[d[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Returns the number of rising edges after the accept edge until out_valid.
  task automatic wait_out(input int which, output int lat);
    bit v;
    lat = 0;
    while (1) begin
      @(negedge clock);
      if (which < 0) v = out_valid;
      else v = x_out_valid[which[1:0]];
      if (v) break;
      if (lat >= 40) begin
        checks++;
        failures++;
        $display("FAIL wait_out_timeout actual=%0d required=out_valid", lat);
        lat = -1;
        break;
      end
      @(posedge clock);
      lat++;
    end
  endtask

  // Reference model: a block accepted now is ready NG edges later, then held until taken.
  always @(posedge clock) begin : model
    int nb;
    bit nh;
    bit acc;
    nb = m_busy;
    nh = m_have;
    if (!reset_n) begin
      m_busy <= 0;
      m_have <= 1'b0;
      m_zero <= 1'b1;
    end else begin
      acc = in_valid && (nb == 0) && (!nh || out_ready);
      if (nh && out_ready) nh = 1'b0;
      if (nb > 0) begin
        nb = nb - 1;
        if (nb == 0) nh = 1'b1;
      end
      if (acc) begin
        nb = NG;
        m_data <= model_sub(state_in);
        m_zero <= 1'b0;
      end
      m_busy <= nb;
      m_have <= nh;
    end
    mdl_started <= 1'b1;
  end

  always @(negedge clock) begin
    if (mdl_started) begin
      chk("cyc_in_ready", in_ready, (m_busy == 0) && (!m_have || out_ready));
      chk("cyc_out_valid", out_valid, m_have);
      chk("cyc_busy", busy, m_busy != 0);
      if (m_have) chk("cyc_state_out", state_out, m_data);
      else if (m_zero) chk("cyc_state_out_zero", state_out, '0);
      if (out_valid && out_ready) dut_xfers++;
    end
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int snap;
    int exp_ng [4] = '{16, 8, 2, 1};
    logic [7:0] s;

    for (int i = 0; i < 256; i++) begin
      s = fwd_sbox(8'(i));
      minv[s] = 8'(i);
    end
    chk("model_fips", model_sub(FIPS_IN), FIPS_OUT);
    chk("model_corner", model_sub(CORNER_IN), CORNER_OUT);

    // Reset with in_valid asserted: nothing may be accepted.
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    state_in   = FIPS_IN;
    x_in_valid = 4'b0000;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state_out", state_out, '0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick;
    chk("post_rst_busy", busy, 1'b0);

    // FIPS-197 vector.
    state_in = FIPS_IN;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_out(-1, lat);
    chk("fips_latency", lat, NG);
    chk("fips_data", state_out, FIPS_OUT);
    tick;

    // S-box corners on the default width.
    state_in = CORNER_IN;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_out(-1, lat);
    chk("corner_latency", lat, NG);
    chk("corner_data", state_out, CORNER_OUT);
    tick;

    // Backpressure: hold DONE for 10 cycles, then exactly one transfer.
    out_ready = 1'b0;
    state_in  = CORNER_IN;
    in_valid  = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_out(-1, lat);
    chk("bp_latency", lat, NG);
    repeat (10) begin
      tick;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_data", state_out, CORNER_OUT);
    end
    snap = dut_xfers;
    out_ready = 1'b1;
    tick;
    tick;
    tick;
    chk("bp_idle_valid", out_valid, 1'b0);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_one_xfer", dut_xfers, snap + 1);

    // Back-to-back: second block accepted on the transfer edge of the first.
    snap = dut_xfers;
    state_in = FIPS_IN;
    in_valid = 1'b1;
    tick;
    state_in = CORNER_IN;
    wait_out(-1, lat);
    chk("b2b_lat_a", lat, NG);
    chk("b2b_data_a", state_out, FIPS_OUT);
    chk("b2b_ready_a", in_ready, 1'b1);
    tick;
    in_valid = 1'b0;
    wait_out(-1, lat);
    chk("b2b_lat_b", lat, NG);
    chk("b2b_data_b", state_out, CORNER_OUT);
    tick;
    tick;
    chk("b2b_xfers", dut_xfers, snap + 2);

    // Reset during the second SUB cycle discards the block.
    snap = dut_xfers;
    state_in = FIPS_IN;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    reset_n = 1'b0;
    tick;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_state_out", state_out, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    repeat (8) tick;
    chk("midrst_no_emit", dut_xfers, snap);

    // Corner block on the other widths: latency 16, 8, 2, 1.
    for (int j = 0; j < 4; j++) begin
      state_in      = CORNER_IN;
      x_in_valid[j] = 1'b1;
      tick;
      x_in_valid[j] = 1'b0;
      wait_out(j, lat);
      chk("x_latency", lat, exp_ng[j]);
      chk("x_data", x_state_out[j], CORNER_OUT);
      tick;
      chk("x_drained", x_out_valid[j], 1'b0);
      chk("x_idle_ready", x_in_ready[j], 1'b1);
      chk("x_idle_busy", x_busy[j], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
